ami_req_in_queue: RTL
=====================

Name: ami_req_in_queue

Overview:
- Input queue for incoming AMIRequests, directly upstream of the block buffer. Buffers up to DEPTH request bus words and presents the head request first-word-fall-through.
- Pre-decodes the head address into sector index (addr[5:3]) and block address (addr[63:6]) so the buffer FSM reads them without its own decode.
- Backpressures the AMI request source through enq_ready.

Parameters:
- DEPTH, 4, number of entries; power of 2, >= 2.
- REQ_WIDTH, 648, request bus width (1 valid + 1 isWrite + 64 addr + 576 data + 6 size).
- ADDR_WIDTH, 64, address field width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- enq_req  input  REQ_WIDTH  incoming request bus. Fields: bit 0 valid, bit 1 isWrite, [65:2] addr, [641:66] data, [647:642] size.
- enq_ready  output  1  queue can accept a request this cycle.
- deq_req  output  REQ_WIDTH  head request. All zeros when empty.
- deq_en  input  1  pop head this cycle.
- deq_sector_index  output  3  head addr[5:3]; 0 when empty.
- deq_block_addr  output  ADDR_WIDTH-6  head addr[63:6]; 0 when empty.
- count  output  clog2(DEPTH+1)  current occupancy.
- underflow_err  output  1  sticky: deq_en asserted while empty.

Interface: one clock, clk. rst is synchronous and active-high.

Behaviour:
- Reset (sampled at a clk edge with rst=1):
  - Read pointer, write pointer and count go to 0.
  - underflow_err clears to 0.
  - deq_req, deq_sector_index and deq_block_addr are 0.
  - enq_ready is 0 while rst is high, and 1 from the first cycle after rst is released.
- Enqueue: accepted when enq_req[0]=1 and enq_ready=1.
  - The entire bus, including bit 0, is written at the write pointer.
  - The write pointer increments modulo DEPTH.
  - enq_req with bit 0 = 0 is ignored.
- enq_ready = !rst && (count != DEPTH).
  - Combinational from registered state only; it does not depend on deq_en.
  - A full queue refuses enqueue even when deq_en=1 in the same cycle.
- Dequeue: when deq_en=1 and count != 0, the read pointer increments modulo DEPTH.
  - deq_req is driven combinationally from storage at the read pointer.
  - An entry written at edge N is visible on deq_req from cycle N+1, giving 1-cycle latency from enqueue to head.
- Empty: deq_req is forced to all zeros, so valid bit 0 = 0.
  - deq_en=1 while empty leaves pointers and count unchanged and sets underflow_err=1.
  - underflow_err holds until rst.
- Simultaneous enqueue and dequeue with 0 < count < DEPTH: both happen and count is unchanged.
- Count update: count increments on enqueue-only, decrements on dequeue-only, and is otherwise held. It never exceeds DEPTH and never goes below 0.
- Wrap-around: pointers are clog2(DEPTH) bits and wrap naturally. Full versus empty is resolved by count, not by pointer compare.
- Sector decode: deq_sector_index = deq_req[7:5] (addr[5:3]); deq_block_addr = deq_req[65:8] (addr[63:6]).
  - These are pure slices of the gated head, so they are 0 when empty.
  - Address bits [2:0] are carried in the stored bus and ignored.
- Reset during operation: all queued entries are discarded in that cycle. Storage contents need not be cleared, because gating by count masks them.
- Storage contents are not reset. Only pointers, count and flags are.

Optional Feature:
- Macro: AMI_REQ_QUEUE_HWM_EN.
- Defined:
  - Adds output port hwm, width clog2(DEPTH+1).
  - hwm is a register reset to 0 that updates to next-count whenever next-count > hwm.
  - It holds otherwise, including when count falls.
  - It is cleared only by rst.
- Undefined: no hwm port and no associated logic; all other behaviour is identical.

Test Plan:
- Reset then idle:
  - Required response: count=0, deq_req=0, enq_ready=1, underflow_err=0.
- Single enqueue, addr=0x1000_0028, isWrite=1, size=6'd8:
  - Next cycle: deq_req[0]=1, deq_sector_index=3'd5, deq_block_addr=0x40_0000.
  - deq_en=1 for one cycle -> count returns to 0 and deq_req=0.
- Fill to DEPTH=4 with addrs 0x00, 0x08, 0x10, 0x18:
  - After 4 accepts: enq_ready=0 and count=4.
  - A fifth enqueue with deq_en=1 in the same cycle is not accepted: count=3, and the head becomes addr 0x08.
- Wrap-around: run 10 enqueues interleaved with 10 dequeues at steady count=2.
  - Dequeued addrs must match enqueue order exactly, and sector indices must cycle 0..7.
- Underflow: deq_en=1 while empty.
  - underflow_err=1 from the next cycle; count stays 0.
  - underflow_err remains 1 after subsequent normal traffic until rst.
- Reset mid-operation: count=3, then rst=1 for one cycle.
  - Next cycle: count=0 and deq_req=0.
  - With AMI_REQ_QUEUE_HWM_EN defined, hwm reads 3 before the reset and 0 after.

Source files
------------

// File: rtl/ami_req_in_queue.sv
// ami_req_in_queue
// Input queue for incoming AMI requests, sitting directly upstream of the
// block buffer. It holds up to DEPTH request bus words and presents the head
// first-word-fall-through. The head address is pre-decoded into a sector
// index (addr[5:3]) and a block address (addr[63:6]).
//
// Request bus layout: [0] valid, [1] isWrite, [65:2] addr, [641:66] data,
// [647:642] size.
//
// Optional feature: define AMI_REQ_QUEUE_HWM_EN to add the hwm output, a
// high-water mark of occupancy that is cleared only by rst.
//
// Full and empty are resolved by the occupancy counter rather than by
// comparing pointers, so the pointers are plain clog2(DEPTH)-bit values
// that wrap naturally.

module ami_req_in_queue #(
    parameter int DEPTH      = 4,
    parameter int REQ_WIDTH  = 648,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REQ_WIDTH-1:0]         enq_req,
    output logic                         enq_ready,
    output logic [REQ_WIDTH-1:0]         deq_req,
    input  logic                         deq_en,
    output logic [2:0]                   deq_sector_index,
    output logic [ADDR_WIDTH-7:0]        deq_block_addr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         underflow_err
`ifdef AMI_REQ_QUEUE_HWM_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]   hwm
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    // Field positions inside the request bus.
    localparam int ADDR_LSB   = 2;
    localparam int ADDR_MSB   = ADDR_LSB + ADDR_WIDTH - 1;
    localparam int SECTOR_LSB = ADDR_LSB + 3;
    localparam int BLOCK_LSB  = ADDR_LSB + 6;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};

    // Storage is deliberately not reset; the occupancy count masks stale data.
    logic [REQ_WIDTH-1:0] mem_r [DEPTH];

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             underflow_r;

    logic             empty_s;
    logic             full_s;
    logic             ready_s;
    logic             do_enq_s;
    logic             do_deq_s;
    logic             underflow_hit_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic [REQ_WIDTH-1:0] head_s;

    // Occupancy flags and handshake qualifiers, derived from registered state.
    // enq_ready intentionally ignores deq_en, so a full queue refuses a write
    // even in a cycle where the head is being popped.
    always_comb begin
        empty_s         = (count_r == CNT_ZERO);
        full_s          = (count_r == DEPTH_CNT);
        ready_s         = (!rst) && (!full_s);
        do_enq_s        = enq_req[0] && ready_s;
        do_deq_s        = deq_en && (!empty_s);
        underflow_hit_s = deq_en && empty_s;
    end

    // Next occupancy: up on enqueue-only, down on dequeue-only, else held.
    always_comb begin
        count_nxt_s = count_r;
        case ({do_enq_s, do_deq_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and occupancy registers; rst discards every queued entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (do_enq_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_deq_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // Entry storage: the whole bus, valid bit included, lands at the write pointer.
    always_ff @(posedge clk) begin
        if (do_enq_s) begin
            mem_r[wr_ptr_r] <= enq_req;
        end
    end

    // Sticky underflow flag: a pop attempt on an empty queue, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_r <= 1'b0;
        end else if (underflow_hit_s) begin
            underflow_r <= 1'b1;
        end
    end

    // Head presentation: storage at the read pointer, forced to zero when empty.
    always_comb begin
        if (empty_s) begin
            head_s = {REQ_WIDTH{1'b0}};
        end else begin
            head_s = mem_r[rd_ptr_r];
        end
    end

`ifdef AMI_REQ_QUEUE_HWM_EN
    logic [CNT_W-1:0] hwm_r;

    // High-water mark: follows the next occupancy upward, never downward.
    always_ff @(posedge clk) begin
        if (rst) begin
            hwm_r <= CNT_ZERO;
        end else if (count_nxt_s > hwm_r) begin
            hwm_r <= count_nxt_s;
        end
    end

    assign hwm = hwm_r;
`endif

    // Address pre-decode is a pure slice of the gated head, so it reads 0 when empty.
    assign deq_req          = head_s;
    assign deq_sector_index = head_s[SECTOR_LSB+2:SECTOR_LSB];
    assign deq_block_addr   = head_s[ADDR_MSB:BLOCK_LSB];
    assign enq_ready        = ready_s;
    assign count            = count_r;
    assign underflow_err    = underflow_r;

endmodule
